// File: rtl/rf_port_sequencer.sv
// Port sequencer for register_block: arbitrates operand reads against writebacks
// on the shared warp selector and returns operands through a one-entry response slot.
module rf_port_sequencer #(
  parameter int NUM_LANES    = 8,
  parameter int NUM_WARPS    = 16,
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int WARP_W       = $clog2(NUM_WARPS),
  parameter int REG_W        = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req_valid,
  output logic                          rd_req_ready,
  input  logic [WARP_W-1:0]             rd_req_warp,
  input  logic [REG_W-1:0]              rd_req_src0,
  input  logic [REG_W-1:0]              rd_req_src1,
  input  logic [NUM_LANES-1:0]          rd_req_mask,
  input  logic [3:0]                    rd_req_tag,
  output logic                          rd_rsp_valid,
  input  logic                          rd_rsp_ready,
  output logic [3:0]                    rd_rsp_tag,
  output logic [NUM_LANES*DATA_W-1:0]   rd_rsp_op0,
  output logic [NUM_LANES*DATA_W-1:0]   rd_rsp_op1,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [WARP_W-1:0]             wb_warp,
  input  logic [REG_W-1:0]              wb_addr,
  input  logic [NUM_LANES-1:0]          wb_mask,
  input  logic [NUM_LANES*DATA_W-1:0]   wb_data,
  output logic [WARP_W-1:0]             rf_warp_selector,
  output logic [NUM_LANES-1:0]          rf_read_en_0,
  output logic [NUM_LANES-1:0]          rf_read_en_1,
  output logic [REG_W-1:0]              rf_raddr_0,
  output logic [REG_W-1:0]              rf_raddr_1,
  output logic [NUM_LANES-1:0]          rf_write_en,
  output logic [REG_W-1:0]              rf_waddr,
  output logic [NUM_LANES*DATA_W-1:0]   rf_wdata,
  input  logic [NUM_LANES*DATA_W-1:0]   rf_rdata_0,
  input  logic [NUM_LANES*DATA_W-1:0]   rf_rdata_1
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                        rsp_valid_reg;
  logic [3:0]                  rsp_tag_reg;
  logic [NUM_LANES*DATA_W-1:0] rsp_op0_reg, rsp_op1_reg;
  logic [NUM_LANES*DATA_W-1:0] op0_next, op1_next;
  logic [STARVE_W-1:0]         starve_cnt_reg;

  logic slot_free, conflict, force_rd, wr_fire, rd_fire;

  assign slot_free = !rsp_valid_reg || rd_rsp_ready;
  assign conflict  = wb_valid && rd_req_valid && (wb_warp != rd_req_warp);
  assign force_rd  = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT)) && slot_free && rd_req_valid;

  assign wb_ready     = !rst && !force_rd;
  assign rd_req_ready = !rst && slot_free && (!conflict || force_rd);
  assign wr_fire      = wb_valid && wb_ready;
  // A read and a write only fire together when their warps agree, so one selector suffices.
  assign rd_fire      = rd_req_valid && rd_req_ready;

  always_comb begin
    rf_warp_selector = '0;
    rf_read_en_0     = '0;
    rf_read_en_1     = '0;
    rf_raddr_0       = '0;
    rf_raddr_1       = '0;
    rf_write_en      = '0;
    rf_waddr         = '0;
    rf_wdata         = '0;
    if (rd_fire) begin
      rf_warp_selector = rd_req_warp;
      rf_read_en_0     = rd_req_mask;
      rf_read_en_1     = rd_req_mask;
      rf_raddr_0       = rd_req_src0;
      rf_raddr_1       = rd_req_src1;
    end
    if (wr_fire) begin
      rf_warp_selector = wb_warp;
      rf_write_en      = wb_mask;
      rf_waddr         = wb_addr;
      rf_wdata         = wb_data;
    end
  end

  // Same-cycle writes are not yet in the array, so matching lanes take the write data.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic byp0, byp1;
    assign byp0 = wr_fire && (wb_addr == rd_req_src0) && wb_mask[gi];
    assign byp1 = wr_fire && (wb_addr == rd_req_src1) && wb_mask[gi];
    assign op0_next[gi*DATA_W +: DATA_W] = byp0 ? wb_data[gi*DATA_W +: DATA_W] :
                                           rd_req_mask[gi] ? rf_rdata_0[gi*DATA_W +: DATA_W] : '0;
    assign op1_next[gi*DATA_W +: DATA_W] = byp1 ? wb_data[gi*DATA_W +: DATA_W] :
                                           rd_req_mask[gi] ? rf_rdata_1[gi*DATA_W +: DATA_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_tag_reg    <= '0;
      rsp_op0_reg    <= '0;
      rsp_op1_reg    <= '0;
      starve_cnt_reg <= '0;
    end else begin
      if (rd_fire) begin
        rsp_valid_reg <= 1'b1;
        rsp_tag_reg   <= rd_req_tag;
        rsp_op0_reg   <= op0_next;
        rsp_op1_reg   <= op1_next;
      end else if (rd_rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
      // Only warp conflicts count as starvation; a full slot is ordinary backpressure.
      if (rd_fire)
        starve_cnt_reg <= '0;
      else if (conflict && slot_free && (starve_cnt_reg != STARVE_W'(STARVE_LIMIT)))
        starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
    end
  end

  assign rd_rsp_valid = rsp_valid_reg;
  assign rd_rsp_tag   = rsp_tag_reg;
  assign rd_rsp_op0   = rsp_op0_reg;
  assign rd_rsp_op1   = rsp_op1_reg;

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Directed bench for rf_port_sequencer with a behavioural register_block and a
// shadow register file holding the values the bench intends to have written.
module tb_rf_port_sequencer;
  localparam int L = 8;
  localparam int D = 64;

  logic clk, rst;
  logic rd_req_valid, rd_req_ready;
  logic [3:0] rd_req_warp, rd_req_src0, rd_req_src1, rd_req_tag;
  logic [L-1:0] rd_req_mask;
  logic rd_rsp_valid, rd_rsp_ready;
  logic [3:0] rd_rsp_tag;
  logic [L*D-1:0] rd_rsp_op0, rd_rsp_op1;
  logic wb_valid, wb_ready;
  logic [3:0] wb_warp, wb_addr;
  logic [L-1:0] wb_mask;
  logic [L*D-1:0] wb_data;
  logic [3:0] rf_warp_selector, rf_raddr_0, rf_raddr_1, rf_waddr;
  logic [L-1:0] rf_read_en_0, rf_read_en_1, rf_write_en;
  logic [L*D-1:0] rf_wdata, rf_rdata_0, rf_rdata_1;

  int tests = 0;
  int fails = 0;

  logic [D-1:0] rf_mem [16][L][16];
  logic [D-1:0] shadow [16][L][16];
  logic [D-1:0] exp0 [L];
  logic [D-1:0] exp1 [L];

  rf_port_sequencer dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_warp(rd_req_warp),
    .rd_req_src0(rd_req_src0), .rd_req_src1(rd_req_src1), .rd_req_mask(rd_req_mask),
    .rd_req_tag(rd_req_tag), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_tag(rd_rsp_tag), .rd_rsp_op0(rd_rsp_op0), .rd_rsp_op1(rd_rsp_op1),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_addr(wb_addr),
    .wb_mask(wb_mask), .wb_data(wb_data), .rf_warp_selector(rf_warp_selector),
    .rf_read_en_0(rf_read_en_0), .rf_read_en_1(rf_read_en_1), .rf_raddr_0(rf_raddr_0),
    .rf_raddr_1(rf_raddr_1), .rf_write_en(rf_write_en), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register_block: combinational read, write commits at the posedge.
  always_comb begin
    rf_rdata_0 = '0;
    rf_rdata_1 = '0;
    for (int l = 0; l < L; l++) begin
      rf_rdata_0[l*D +: D] = rf_mem[rf_warp_selector][l][rf_raddr_0];
      rf_rdata_1[l*D +: D] = rf_mem[rf_warp_selector][l][rf_raddr_1];
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < L; l++)
      if (rf_write_en[l]) rf_mem[rf_warp_selector][l][rf_waddr] <= rf_wdata[l*D +: D];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [3:0] w, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [L-1:0] m);
    for (int l = 0; l < L; l++) begin
      exp0[l] = m[l] ? shadow[w][l][s0] : '0;
      exp1[l] = m[l] ? shadow[w][l][s1] : '0;
    end
  endtask

  task automatic chk_rsp(input string name, input logic [3:0] tag);
    chk({name, "_valid"}, D'(rd_rsp_valid), D'(1));
    chk({name, "_tag"}, D'(rd_rsp_tag), D'(tag));
    for (int l = 0; l < L; l++) begin
      chk($sformatf("%s_op0_l%0d", name, l), rd_rsp_op0[l*D +: D], exp0[l]);
      chk($sformatf("%s_op1_l%0d", name, l), rd_rsp_op1[l*D +: D], exp1[l]);
    end
  endtask

  task automatic shadow_write(input logic [3:0] w, input logic [3:0] a, input logic [L-1:0] m,
                              input logic [L*D-1:0] d);
    for (int l = 0; l < L; l++)
      if (m[l]) shadow[w][l][a] = d[l*D +: D];
  endtask

  initial begin
    logic [L*D-1:0] dv;
    logic [L-1:0] mv;
    for (int w = 0; w < 16; w++)
      for (int l = 0; l < L; l++)
        for (int r = 0; r < 16; r++) begin
          rf_mem[w][l][r] = '0;
          shadow[w][l][r] = '0;
        end

    // Reset with both request sides active.
    rst = 1'b1; rd_rsp_ready = 1'b1;
    rd_req_valid = 1'b1; rd_req_warp = 4'd6; rd_req_src0 = 4'd1; rd_req_src1 = 4'd2;
    rd_req_mask = 8'hFF; rd_req_tag = 4'd1;
    wb_valid = 1'b1; wb_warp = 4'd6; wb_addr = 4'd1; wb_mask = 8'hFF; wb_data = {L{64'hDEAD}};
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_wb_ready", D'(wb_ready), D'(0));
      chk("rst_rd_req_ready", D'(rd_req_ready), D'(0));
      chk("rst_write_en", D'(rf_write_en), D'(0));
      chk("rst_read_en", D'(rf_read_en_0), D'(0));
      chk("rst_selector", D'(rf_warp_selector), D'(0));
      tick();
      chk("rst_rsp_valid", D'(rd_rsp_valid), D'(0));
      chk("rst_rsp_tag", D'(rd_rsp_tag), D'(0));
      chk("rst_rsp_op0", rd_rsp_op0[D-1:0], D'(0));
    end
    rst = 1'b0; rd_req_valid = 1'b0; wb_valid = 1'b0;
    $display("[TB] reset phase done");

    // Write warp 3 reg 5, then read it back.
    for (int l = 0; l < L; l++) dv[l*D +: D] = 64'hA5A5_0000_0000_0000 | 64'(l);
    wb_valid = 1'b1; wb_warp = 4'd3; wb_addr = 4'd5; wb_mask = 8'hFF; wb_data = dv;
    #1;
    chk("wr_wb_ready", D'(wb_ready), D'(1));
    chk("wr_write_en", D'(rf_write_en), D'(8'hFF));
    chk("wr_selector", D'(rf_warp_selector), D'(3));
    chk("wr_waddr", D'(rf_waddr), D'(5));
    shadow_write(4'd3, 4'd5, 8'hFF, dv);
    tick();
    wb_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_warp = 4'd3; rd_req_src0 = 4'd5; rd_req_src1 = 4'd5;
    rd_req_mask = 8'hFF; rd_req_tag = 4'd9;
    set_exp(4'd3, 4'd5, 4'd5, 8'hFF);
    #1;
    chk("rd_req_ready", D'(rd_req_ready), D'(1));
    chk("rd_selector", D'(rf_warp_selector), D'(3));
    chk("rd_raddr_0", D'(rf_raddr_0), D'(5));
    chk("rd_read_en_1", D'(rf_read_en_1), D'(8'hFF));
    tick();
    rd_req_valid = 1'b0;
    chk_rsp("wr_then_rd", 4'd9);
    tick();
    chk("rsp_drop", D'(rd_rsp_valid), D'(0));
    $display("[TB] write/read warp 3 reg 5 tag 9");

    // Same-cycle bypass on lanes 0-3 over old array data.
    for (int l = 0; l < L; l++) dv[l*D +: D] = 64'hB0B0_0000_0000_0000 | 64'(l);
    wb_valid = 1'b1; wb_warp = 4'd2; wb_addr = 4'd7; wb_mask = 8'hFF; wb_data = dv;
    shadow_write(4'd2, 4'd7, 8'hFF, dv);
    tick();
    for (int l = 0; l < L; l++) dv[l*D +: D] = 64'hC0C0_0000_0000_0000 | 64'(l);
    wb_mask = 8'h0F; wb_data = dv;
    rd_req_valid = 1'b1; rd_req_warp = 4'd2; rd_req_src0 = 4'd7; rd_req_src1 = 4'd7;
    rd_req_mask = 8'hFF; rd_req_tag = 4'd3;
    for (int l = 0; l < L; l++) begin
      exp0[l] = (l < 4) ? dv[l*D +: D] : (64'hB0B0_0000_0000_0000 | 64'(l));
      exp1[l] = exp0[l];
    end
    #1;
    chk("byp_rd_ready", D'(rd_req_ready), D'(1));
    chk("byp_wb_ready", D'(wb_ready), D'(1));
    shadow_write(4'd2, 4'd7, 8'h0F, dv);
    tick();
    wb_valid = 1'b0;
    chk_rsp("bypass", 4'd3);
    rd_req_mask = 8'h81; rd_req_tag = 4'd4;
    set_exp(4'd2, 4'd7, 4'd7, 8'h81);
    tick();
    rd_req_valid = 1'b0;
    chk_rsp("mask81", 4'd4);
    $display("[TB] bypass warp 2 reg 7 and mask 81 read");

    // Conflict: continuous writes to warp 1 starve a read of warp 4.
    wb_valid = 1'b1; wb_warp = 4'd1; wb_addr = 4'd0; wb_mask = 8'h01; wb_data = {L{64'h1111}};
    shadow_write(4'd1, 4'd0, 8'h01, wb_data);
    rd_req_valid = 1'b1; rd_req_warp = 4'd4; rd_req_src0 = 4'd0; rd_req_src1 = 4'd1;
    rd_req_mask = 8'hFF; rd_req_tag = 4'd7;
    set_exp(4'd4, 4'd0, 4'd1, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("starve_c%0d_rd_ready", c), D'(rd_req_ready), D'(0));
      chk($sformatf("starve_c%0d_wb_ready", c), D'(wb_ready), D'(1));
      chk($sformatf("starve_c%0d_sel", c), D'(rf_warp_selector), D'(1));
      tick();
    end
    #1;
    chk("force_cnt", D'(dut.starve_cnt_reg), D'(4));
    chk("force_wb_ready", D'(wb_ready), D'(0));
    chk("force_rd_ready", D'(rd_req_ready), D'(1));
    chk("force_sel", D'(rf_warp_selector), D'(4));
    chk("force_write_en", D'(rf_write_en), D'(0));
    tick();
    rd_req_valid = 1'b0;
    chk_rsp("forced", 4'd7);
    #1;
    chk("after_force_cnt", D'(dut.starve_cnt_reg), D'(0));
    chk("after_force_wb_ready", D'(wb_ready), D'(1));
    tick();
    wb_valid = 1'b0;
    $display("[TB] starvation forced read warp 4 tag 7");

    // Backpressure: response held while writes continue.
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_warp = 4'd3; rd_req_src0 = 4'd5; rd_req_src1 = 4'd5;
    rd_req_mask = 8'hFF; rd_req_tag = 4'd5;
    set_exp(4'd3, 4'd5, 4'd5, 8'hFF);
    tick();
    rd_req_warp = 4'd2; rd_req_src0 = 4'd7; rd_req_src1 = 4'd7; rd_req_tag = 4'd6;
    for (int l = 0; l < L; l++) dv[l*D +: D] = 64'hD0D0_0000_0000_0000 | 64'(l);
    wb_valid = 1'b1; wb_warp = 4'd2; wb_addr = 4'd9; wb_mask = 8'hFF; wb_data = dv;
    shadow_write(4'd2, 4'd9, 8'hFF, dv);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_c%0d_rd_ready", c), D'(rd_req_ready), D'(0));
      chk($sformatf("bp_c%0d_wb_ready", c), D'(wb_ready), D'(1));
      chk($sformatf("bp_c%0d_write_en", c), D'(rf_write_en), D'(8'hFF));
      chk($sformatf("bp_c%0d_valid", c), D'(rd_rsp_valid), D'(1));
      chk($sformatf("bp_c%0d_tag", c), D'(rd_rsp_tag), D'(5));
      chk($sformatf("bp_c%0d_op1_l2", c), rd_rsp_op1[2*D +: D], exp1[2]);
      tick();
    end
    rd_rsp_ready = 1'b1;
    set_exp(4'd2, 4'd7, 4'd7, 8'hFF);
    #1;
    chk("bp_release_rd_ready", D'(rd_req_ready), D'(1));
    tick();
    rd_req_valid = 1'b0; wb_valid = 1'b0;
    chk_rsp("bp_next", 4'd6);
    tick();
    chk("bp_drain", D'(rd_rsp_valid), D'(0));
    $display("[TB] backpressure held tag 5, then tag 6");

    // Sweep every warp and register with random data and masks.
    for (int w = 0; w < 16; w++) begin
      for (int r = 0; r < 16; r++) begin
        for (int l = 0; l < L; l++) dv[l*D +: D] = {$urandom, $urandom};
        mv = 8'($urandom_range(0, 255));
        wb_valid = 1'b1; wb_warp = 4'(w); wb_addr = 4'(r); wb_mask = mv; wb_data = dv;
        shadow_write(4'(w), 4'(r), mv, dv);
        tick();
        wb_valid = 1'b0;
        mv = 8'($urandom_range(0, 255));
        rd_req_valid = 1'b1; rd_req_warp = 4'(w); rd_req_src0 = 4'(r);
        rd_req_src1 = 4'((r + 3) % 16); rd_req_mask = mv; rd_req_tag = 4'((w + r) % 16);
        set_exp(4'(w), 4'(r), 4'((r + 3) % 16), mv);
        tick();
        rd_req_valid = 1'b0;
        chk_rsp($sformatf("sweep_w%0d_r%0d", w, r), 4'((w + r) % 16));
        $display("[TB] sweep warp %0d reg %0d mask %02h", w, r, mv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_port_sequencer.md
# rf_port_sequencer

Front-end sequencer that owns all ports of `register_block` (8 lanes, 16 warps, 16 registers, 64-bit). It accepts operand-read requests from issue and writeback requests from execute. Each cycle it drives one shared `warp_selector`, both read ports and the write port. Read operands are returned through a registered valid/ready response stage, with same-cycle write-to-read bypass.

## Interface
- NUM_LANES, 8, lanes per warp
- NUM_WARPS, 16, warps; WARP_W = 4
- NUM_REGS, 16, registers per lane; REG_W = 4
- DATA_W, 64, register width
- STARVE_LIMIT, 4, consecutive conflict-stalled read cycles before a read is forced ahead of writeback
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_req_valid  in  1  operand-read request valid
- rd_req_ready  out  1  request accepted when valid && ready
- rd_req_warp  in  WARP_W  warp of request
- rd_req_src0, rd_req_src1  in  REG_W  source register addresses
- rd_req_mask  in  NUM_LANES  active-lane mask
- rd_req_tag  in  4  opaque tag, returned with response
- rd_rsp_valid  out  1  response valid
- rd_rsp_ready  in  1  consumer accepts response
- rd_rsp_tag  out  4  tag of response
- rd_rsp_op0, rd_rsp_op1  out  NUM_LANES*DATA_W  lane l at bits [l*DATA_W +: DATA_W]
- wb_valid  in  1  writeback valid
- wb_ready  out  1  writeback accepted when valid && ready
- wb_warp  in  WARP_W; wb_addr  in  REG_W; wb_mask  in  NUM_LANES
- wb_data  in  NUM_LANES*DATA_W  write data, lane-packed
- rf_warp_selector  out  WARP_W  to register_block
- rf_read_en_0, rf_read_en_1  out  NUM_LANES  per-lane read enables
- rf_raddr_0, rf_raddr_1  out  REG_W  read addresses
- rf_write_en  out  NUM_LANES  per-lane write enables
- rf_waddr  out  REG_W; rf_wdata  out  NUM_LANES*DATA_W
- rf_rdata_0, rf_rdata_1  in  NUM_LANES*DATA_W  combinational read data from register_block

## Operation
- register_block reads are combinational within a cycle. Writes commit at the posedge ending the cycle in which rf_write_en is asserted.
- The response slot holds one entry. `slot_free = !rd_rsp_valid || rd_rsp_ready`.
- `conflict = wb_valid && rd_req_valid && (wb_warp != rd_req_warp)`.
- `force_rd = (starve_cnt == STARVE_LIMIT) && slot_free && rd_req_valid`.
- `wb_ready = !rst && !force_rd`.
- `rd_req_ready = !rst && slot_free && (!conflict || force_rd)`.
- Write fire (wb_valid && wb_ready) drives:
  - rf_write_en = wb_mask
  - rf_waddr = wb_addr
  - rf_wdata = wb_data
  - rf_warp_selector = wb_warp
- Read fire drives:
  - rf_read_en_0 = rf_read_en_1 = rd_req_mask
  - rf_raddr_0 = src0, rf_raddr_1 = src1
  - rf_warp_selector = rd_req_warp
- Warp selector priority: the write warp when a write fires, else the read warp when a read fires, else 0. Both fire in the same cycle only when the warps match.
- Unfired ports drive enables 0; rf_raddr_x, rf_waddr and rf_wdata then drive 0.
- Capture on read fire, per port p and lane l:
  - If a write fires this cycle with wb_addr == src_p and wb_mask[l], capture wb_data lane l (bypass).
  - Else if rd_req_mask[l], capture rf_rdata_p lane l.
  - Else capture 0.
- starve_cnt (0..STARVE_LIMIT):
  - Clears on read fire.
  - Increments when `conflict && slot_free` and no read fires.
  - Otherwise holds.
- Stall reasons: slot-full stalls do not count toward starvation. When forced, the writeback stalls for exactly one cycle.

## Timing
- Reset values:
  - rd_rsp_valid = 0, rd_rsp_tag = 0, rd_rsp_op0 = rd_rsp_op1 = 0, starve_cnt = 0.
  - While rst is high: rd_req_ready = 0, wb_ready = 0, and all rf_* outputs are 0.
- Read latency: a request fires in cycle N; rd_rsp_valid rises at the posedge ending N, i.e. it is visible in N+1.
- The response holds stable until rd_rsp_ready. Back-to-back responses reach full throughput when rd_rsp_ready is held high.
- On response accept with no new fire, rd_rsp_valid falls at the next posedge.
- Write visibility:
  - A write in cycle N is readable from the array in N+1.
  - In cycle N it is readable only via the bypass.
- Reset mid-operation: a pending response is dropped and starve_cnt clears. No rf write is issued in a cycle in which rst is high.

## Test plan
- Reset: hold rst 2 cycles with wb_valid=rd_req_valid=1 -> wb_ready=0, rd_req_ready=0, rf_write_en=0, rd_rsp_valid=0.
- Write then read: write warp 3, reg 5, mask FF, lane l data = 64'hA5A5_0000_0000_0000 | l; next cycle read src0=src1=5, mask FF -> one cycle later rd_rsp_op0 = rd_rsp_op1 = written data, tag echoed.
- Bypass and mask: in the same cycle, write warp 2 reg 7 with mask 0F and new data, and read warp 2 src0=7, mask FF -> lanes 0-3 carry the new data and lanes 4-7 the old array data. With read mask 0x81 -> lanes 1-6 are 0.
- Warp conflict and starvation: write warp 1 continuously and read warp 4 -> read stalls 4 cycles, then in cycle 5 wb_ready=0, the read fires, rf_warp_selector=4 and starve_cnt returns to 0.
- Backpressure: rd_rsp_ready=0 with a valid response -> rd_req_ready=0, the response is held stable for 5 cycles and writes continue; release -> the next read fires in the same cycle as the accept.
- Sweep: all 16 warps x 16 regs x random lane data with random masks, compared per lane against a scoreboard on both response ports.
